// File: rtl/fifo_reader_tx.sv
// fifo_reader_tx: pops bytes from a first-word fall-through FIFO and sends
// each one as an 8N1 serial frame (start bit, 8 data bits LSB first, stop bit).
// The pop strobe is combinational so the byte is captured on the same edge
// that pops it. All other outputs are registered.

module fifo_reader_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       empty,
    input  logic [7:0] din,
    output logic       re,
    output logic       txd,
    output logic       busy,
    output logic       done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_PRE  = CW'(CLKS_PER_BIT - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t         state;
    logic [CW-1:0]  baud_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shift_reg;
    logic           baud_end;

    // Last cycle of the current bit period
    assign baud_end = (baud_cnt == BAUD_LAST);

    // Pop only from IDLE and never while reset is asserted
    assign re = (state == IDLE) & enable & ~empty & rst;

    // Frame sequencer: state, baud timing, shifting and registered line outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'd0;
            txd       <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    txd      <= 1'b1;
                    busy     <= 1'b0;
                    baud_cnt <= '0;
                    bit_idx  <= 3'd0;
                    if (re) begin
                        shift_reg <= din;
                        state     <= START;
                        txd       <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= 3'd0;
                        state    <= DATA;
                        txd      <= shift_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            txd       <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_cnt == BAUD_PRE) begin
                        done <= 1'b1;
                    end
                    if (baud_end) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_reader_tx.sv
// tb_fifo_reader_tx: directed bench for fifo_reader_tx with CLKS_PER_BIT=4.
// A small FWFT FIFO model feeds the DUT; frames are checked cycle by cycle
// against the expected 8N1 waveform built from the pushed byte.

module tb_fifo_reader_tx;

    localparam int CPB = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       empty;
    logic [7:0] din;
    logic       re;
    logic       txd;
    logic       busy;
    logic       done;

    logic [7:0] mem [0:15];
    logic [3:0] wr_ptr;
    logic [3:0] rd_ptr;
    int         cyc;
    logic       prev_re;

    int errors;
    int checks;

    fifo_reader_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .empty  (empty),
        .din    (din),
        .re     (re),
        .txd    (txd),
        .busy   (busy),
        .done   (done)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FWFT FIFO model: head is visible whenever not empty
    assign empty = (rd_ptr == wr_ptr);
    assign din   = mem[rd_ptr];

    // Pop the FIFO on each edge that sees re, and count cycles
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (re) begin
            rd_ptr <= rd_ptr + 4'd1;
        end
    end

    // re must never repeat on consecutive cycles and may only occur in IDLE
    always @(posedge clk) begin
        if (re) begin
            checks++;
            assert (!prev_re && !busy && dut.state == 2'd0) else begin
                errors++;
                $error("FAIL re_protocol: observed prev_re=%0b busy=%0b state=%0d required prev_re=0 busy=0 state=0",
                       prev_re, busy, dut.state);
            end
        end
        prev_re = re;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    // Advance to the next falling edge and let outputs settle
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Wait (bounded) until re is observed high in the settled part of a cycle
    task automatic wait_re(input int max_cycles, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (re) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check_output(tag, {31'd0, found}, 32'd1);
    endtask

    function automatic logic exp_txd(input logic [7:0] b, input int k);
        if (k <= CPB) return 1'b0;
        if (k <= 9 * CPB) return b[(k - CPB - 1) / CPB];
        return 1'b1;
    endfunction

    // Check a full frame starting from the cycle where re was seen;
    // drops enable at cycle drop_k when drop_k > 0
    task automatic check_frame(input logic [7:0] b, input int drop_k, input string tag);
        for (int k = 1; k <= FRAME; k++) begin
            step();
            if (k == drop_k) enable = 1'b0;
            check_output({tag, "_txd"}, {31'd0, txd}, {31'd0, exp_txd(b, k)});
            check_output({tag, "_busy"}, {31'd0, busy}, 32'd1);
            check_output({tag, "_done"}, {31'd0, done}, {31'd0, (k == FRAME)});
            check_output({tag, "_re"}, {31'd0, re}, 32'd0);
        end
    endtask

    initial begin
        int t_first;
        errors  = 0;
        checks  = 0;
        cyc     = 0;
        wr_ptr  = 4'd0;
        rd_ptr  = 4'd0;
        prev_re = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'd0;
        rst    = 1'b0;
        enable = 1'b1;

        // Reset state, with data available and enable high
        push(8'hA5);
        step();
        step();
        check_output("rst_txd", {31'd0, txd}, 32'd1);
        check_output("rst_busy", {31'd0, busy}, 32'd0);
        check_output("rst_done", {31'd0, done}, 32'd0);
        check_output("rst_re", {31'd0, re}, 32'd0);

        // Single byte 0xA5
        rst = 1'b1;
        #1;
        wait_re(5, "a5_re");
        check_frame(8'hA5, 0, "a5");
        step();
        check_output("a5_idle_busy", {31'd0, busy}, 32'd0);
        check_output("a5_idle_txd", {31'd0, txd}, 32'd1);
        check_output("a5_no_more_re", {31'd0, re}, 32'd0);

        // Back-to-back 0x00 then 0xFF
        push(8'h00);
        push(8'hFF);
        #1;
        wait_re(5, "b2b_re1");
        t_first = cyc;
        check_frame(8'h00, 0, "b2b0");
        step();
        check_output("b2b_re2", {31'd0, re}, 32'd1);
        check_output("b2b_period", cyc - t_first, FRAME + 1);
        check_frame(8'hFF, 0, "b2bf");
        step();

        // Idle hold with an empty FIFO
        for (int i = 0; i < 100; i++) begin
            check_output("idle_re", {31'd0, re}, 32'd0);
            check_output("idle_txd", {31'd0, txd}, 32'd1);
            check_output("idle_busy", {31'd0, busy}, 32'd0);
            step();
        end

        // Enable gating, then drop enable during data bit 3
        enable = 1'b0;
        push(8'h3C);
        push(8'h81);
        for (int i = 0; i < 20; i++) begin
            step();
            check_output("gate_re", {31'd0, re}, 32'd0);
        end
        enable = 1'b1;
        #1;
        wait_re(5, "gate_re_start");
        check_frame(8'h3C, 4 * CPB + 2, "gate");
        for (int i = 0; i < 30; i++) begin
            step();
            check_output("gate_after_re", {31'd0, re}, 32'd0);
            check_output("gate_after_busy", {31'd0, busy}, 32'd0);
        end

        // Reset mid-frame during data bit 5
        enable = 1'b1;
        #1;
        wait_re(5, "abort_re");
        for (int k = 1; k <= 6 * CPB + 2; k++) step();
        check_output("abort_pre_busy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_output("abort_txd", {31'd0, txd}, 32'd1);
        check_output("abort_busy", {31'd0, busy}, 32'd0);
        check_output("abort_re", {31'd0, re}, 32'd0);
        push(8'h5A);
        step();
        check_output("abort_hold_re", {31'd0, re}, 32'd0);
        rst = 1'b1;
        #1;
        check_output("restart_re", {31'd0, re}, 32'd1);
        check_frame(8'h5A, 0, "restart");
        step();
        check_output("restart_idle", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
